// File: rtl/inst_mem_sync_if.sv
// Bus interface for inst_mem_sync.
// Groups the program-load port and the fetch port.
//   master : drives load_*/fetch_en/stall/a and observes the status and fetch result.
//   slave  : the memory side, which consumes requests and returns results.
// Signals:
//   load_start, load_we, load_last, load_data : sequential image load port.
//   load_busy, load_count                     : load status.
//   fetch_en, stall, a                        : fetch request, pipeline hold, byte address.
//   inst, inst_valid, fault                   : registered fetch result.
interface inst_mem_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 64
);
  localparam int IDX_W = $clog2(DEPTH);

  logic              load_start;
  logic              load_we;
  logic              load_last;
  logic [DATA_W-1:0] load_data;
  logic              load_busy;
  logic [IDX_W:0]    load_count;
  logic              fetch_en;
  logic              stall;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] inst;
  logic              inst_valid;
  logic              fault;

  modport master (
    output load_start, load_we, load_last, load_data, fetch_en, stall, a,
    input  load_busy, load_count, inst, inst_valid, fault
  );

  modport slave (
    input  load_start, load_we, load_last, load_data, fetch_en, stall, a,
    output load_busy, load_count, inst, inst_valid, fault
  );
endinterface

// File: rtl/inst_mem_sync.sv
// Loadable synchronous instruction memory for the CPU fetch stage.
// DEPTH words of DATA_W bits are written through a sequential load port with
// an auto-incrementing pointer. Fetch is registered (one cycle of latency),
// honours a pipeline stall, and flags misaligned or out-of-range addresses.
// Ports:
//   clk : clock, rising edge.
//   rst : synchronous reset, active-high. The memory array itself is not cleared.
//   bus : inst_mem_sync_if.slave carrying the load port, the fetch port and their results.
module inst_mem_sync #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 64,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  inst_mem_sync_if.slave        bus
);
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W + 1)'(DEPTH);

  logic [0:0]        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W:0]    count;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] inst_p1;
  logic              vld_p1;
  logic              fault_p1;

  logic              in_load;
  logic              do_write;
  logic [IDX_W-1:0]  idx_p0;
  logic              bad_p0;

  // A fetch is bad when it is not word aligned or any address bit above the
  // word index is set.
  function automatic logic fetch_bad(input logic [ADDR_W-1:0] addr);
    fetch_bad = (addr[1:0] != 2'b00) || ((addr >> (IDX_W + 2)) != '0);
  endfunction

  assign in_load  = (state == ST_LOAD);
  // load_start takes precedence over a coincident write.
  assign do_write = in_load && bus.load_we && !bus.load_start;
  assign idx_p0   = bus.a[IDX_W+1:2];
  assign bad_p0   = fetch_bad(bus.a);

  // Load control: the pointer never wraps because a write at the last index
  // returns the FSM to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      ptr   <= '0;
      count <= '0;
    end else if (bus.load_start) begin
      state <= ST_LOAD;
      ptr   <= '0;
      count <= '0;
    end else if (do_write) begin
      ptr <= ptr + 1'b1;
      if (count != FULL_COUNT) begin
        count <= count + 1'b1;
      end
      if (bus.load_last || (ptr == LAST_IDX)) begin
        state <= ST_RUN;
      end
    end
  end

  // Memory array: contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[ptr] <= bus.load_data;
    end
  end

  // ---- stage p0 -> p1: registered fetch ----
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_p1  <= NOP_WORD;
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
    end else if (in_load || bus.load_start) begin
      vld_p1 <= 1'b0;
    end else if (bus.stall) begin
      inst_p1  <= inst_p1;
      vld_p1   <= vld_p1;
      fault_p1 <= fault_p1;
    end else if (bus.fetch_en) begin
      inst_p1  <= bad_p0 ? NOP_WORD : mem[idx_p0];
      vld_p1   <= 1'b1;
      fault_p1 <= bad_p0;
    end else begin
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
    end
  end

  assign bus.load_busy  = in_load;
  assign bus.load_count = count;
  assign bus.inst       = inst_p1;
  assign bus.inst_valid = vld_p1;
  assign bus.fault      = fault_p1;
endmodule
